// File: rtl/gpioemu_prime_ctl_if.sv
// CPU register bus for the GPIO emulator / prime engine: address, level strobes
// and the two data paths.
`timescale 1ns/1ps

interface gpioemu_prime_ctl_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    modport master (output saddress, srd, swr, sdata_in, input sdata_out);
    modport slave  (input saddress, srd, swr, sdata_in, output sdata_out);
endinterface

// File: rtl/gpioemu_prime_ctl.sv
// GPIO emulator with a trial-division prime engine: n-th prime or prime count
// up to N, with abort, done/error flags and a live primes-found counter.
`timescale 1ns/1ps

module gpioemu_prime_ctl #(
    parameter int unsigned N_WIDTH  = 10,
    parameter int unsigned MAX_N    = 1000,
    parameter logic [15:0] ADDR_N    = 16'h288,
    parameter logic [15:0] ADDR_CTRL = 16'h290,
    parameter logic [15:0] ADDR_W    = 16'h298,
    parameter logic [15:0] ADDR_CNT  = 16'h2A8,
    parameter logic [15:0] ADDR_S    = 16'h2A0
) (
    input  logic                 clk,
    input  logic                 n_reset,
    gpioemu_prime_ctl_if.slave   bus,
    input  logic [31:0]          gpio_in,
    input  logic                 gpio_latch,
    output logic [31:0]          gpio_out,
    output logic [31:0]          gpio_in_s_insp
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        CHECK = 2'b11,
        FOUND = 2'b10
    } state_t;

    state_t             state;
    logic               srd_q, swr_q, latch_q;
    logic [N_WIDTH-1:0] n_reg;
    logic               mode;
    logic               done;
    logic               error;
    logic               flag;
    logic [31:0]        w_reg, cnt, cand, div_i;
    logic [31:0]        rd_data;

    logic        rd_edge, wr_edge, latch_edge;
    logic [31:0] wr_val, n_ext, i_sq, rem, cnt_inc, rd_mux;
    logic        wr_bad;
    logic        unused_sdata_bits;

    assign rd_edge    = bus.srd & ~srd_q;
    assign wr_edge    = bus.swr & ~swr_q;
    assign latch_edge = gpio_latch & ~latch_q;

    assign wr_val  = 32'(bus.sdata_in[N_WIDTH-1:0]);
    assign wr_bad  = (wr_val == 32'd0) || (wr_val > MAX_N);
    assign n_ext   = 32'(n_reg);
    assign i_sq    = div_i * div_i;
    assign rem     = cand % div_i;
    assign cnt_inc = cnt + 32'd1;

    assign unused_sdata_bits = ^bus.sdata_in[31:N_WIDTH];
    assign bus.sdata_out     = rd_data;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rd_mux = 32'd0;
        case (bus.saddress)
            ADDR_N:    rd_mux = n_ext;
            ADDR_CTRL: rd_mux = {31'd0, mode};
            ADDR_W:    rd_mux = w_reg;
            ADDR_CNT:  rd_mux = cnt;
            ADDR_S:    rd_mux = {28'd0, error, done, state};
            default:   rd_mux = 32'd0;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the bus-write code sits after
    // the FSM so a write in the same cycle overrides the step (last NBA wins).
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state          <= IDLE;
            srd_q          <= 1'b0;
            swr_q          <= 1'b0;
            latch_q        <= 1'b0;
            n_reg          <= '0;
            mode           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            flag           <= 1'b0;
            w_reg          <= 32'd0;
            cnt            <= 32'd0;
            cand           <= 32'd2;
            div_i          <= 32'd0;
            rd_data        <= 32'd0;
            gpio_out       <= 32'd0;
            gpio_in_s_insp <= 32'd0;
        end else begin
            srd_q    <= bus.srd;
            swr_q    <= bus.swr;
            latch_q  <= gpio_latch;
            gpio_out <= cnt;

            // Read mux samples the registers before any write of this cycle lands.
            if (rd_edge)
                rd_data <= rd_mux;
            if (latch_edge)
                gpio_in_s_insp <= gpio_in;

            case (state)
                IDLE: ;
                CALC: begin
                    if (mode && (cand > n_ext)) begin
                        w_reg <= cnt;
                        state <= FOUND;
                    end else begin
                        div_i <= 32'd2;
                        flag  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    // A cleared flag forces the exit one cycle after the divisor hit.
                    if ((i_sq > cand) || !flag) begin
                        if (flag) begin
                            cnt <= cnt_inc;
                            if (!mode && (cnt_inc == n_ext)) begin
                                w_reg <= cand;
                                state <= FOUND;
                            end else begin
                                cand  <= cand + 32'd1;
                                state <= CALC;
                            end
                        end else begin
                            cand  <= cand + 32'd1;
                            state <= CALC;
                        end
                    end else if (rem == 32'd0) begin
                        flag <= 1'b0;
                    end else begin
                        div_i <= div_i + 32'd1;
                    end
                end
                FOUND: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (wr_edge && (bus.saddress == ADDR_N)) begin
                if (wr_bad) begin
                    error <= 1'b1;
                end else begin
                    n_reg <= bus.sdata_in[N_WIDTH-1:0];
                    error <= 1'b0;
                    done  <= 1'b0;
                    cnt   <= 32'd0;
                    cand  <= 32'd2;
                    state <= CALC;
                end
            end

            if (wr_edge && (bus.saddress == ADDR_CTRL)) begin
                mode <= bus.sdata_in[0];
                if (bus.sdata_in[1]) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpioemu_prime_ctl.sv
// Scoreboard bench for gpioemu_prime_ctl: bus reads push expected data, a
// monitor pops and compares whenever the DUT answers a read edge.
`timescale 1ns/1ps

module tb_gpioemu_prime_ctl;

    localparam logic [15:0] A_N    = 16'h288;
    localparam logic [15:0] A_CTRL = 16'h290;
    localparam logic [15:0] A_W    = 16'h298;
    localparam logic [15:0] A_CNT  = 16'h2A8;
    localparam logic [15:0] A_S    = 16'h2A0;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] gpio_in = 32'd0;
    logic        gpio_latch = 1'b0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in_s_insp;

    gpioemu_prime_ctl_if bus();

    gpioemu_prime_ctl dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .bus            (bus),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
        bit          skip;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rd  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: a read edge seen at a rising edge is answered by that edge.
    initial begin : monitor
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            if (bus.srd && !prev && n_reset) begin
                prev = 1'b1;
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: got 0x%08h expected no read", bus.sdata_out);
                end else begin
                    e = sb_q.pop_front();
                    if (e.skip)
                        last_rd = bus.sdata_out;
                    else
                        check(e.name, bus.sdata_out, e.exp);
                end
            end else begin
                prev = bus.srd;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.saddress = a;
        bus.sdata_in = d;
        bus.swr      = 1'b1;
        @(negedge clk);
        bus.swr      = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a);
        @(negedge clk);
        bus.saddress = a;
        bus.srd      = 1'b1;
        @(negedge clk);
        bus.srd      = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_exp(input logic [15:0] a, input string name, input logic [31:0] exp);
        sb_q.push_back('{name, exp, 1'b0});
        do_read(a);
    endtask

    task automatic rd_peek(input logic [15:0] a);
        sb_q.push_back('{"peek", 32'd0, 1'b1});
        do_read(a);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40000 && !seen; k++) begin
            rd_peek(A_S);
            seen = last_rd[2];
        end
        check({name, "_done"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin : stimulus
        int          changes;
        logic [31:0] prev_out;

        bus.saddress = 16'd0;
        bus.sdata_in = 32'd0;
        bus.srd      = 1'b0;
        bus.swr      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        rd_exp(A_N,    "rst_n",    32'd0);
        rd_exp(A_CTRL, "rst_ctrl", 32'd0);
        rd_exp(A_W,    "rst_w",    32'd0);
        rd_exp(A_CNT,  "rst_cnt",  32'd0);
        rd_exp(A_S,    "rst_s",    32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_insp", gpio_in_s_insp, 32'd0);

        // 10th prime
        wr(A_N, 32'd10);
        rd_peek(A_S);
        check("n10_busy", {31'd0, last_rd[1:0] != 2'b00}, 32'd1);
        wait_done("n10");
        rd_exp(A_W,   "n10_w",   32'd29);
        rd_exp(A_CNT, "n10_cnt", 32'd10);
        rd_exp(A_S,   "n10_s",   32'd4);
        check("n10_gpio_out", gpio_out, 32'd10);

        // Largest N, then prime count up to 100
        wr(A_N, 32'd1000);
        wait_done("n1000");
        rd_exp(A_W, "n1000_w", 32'd7919);
        rd_exp(A_S, "n1000_s", 32'd4);
        wr(A_CTRL, 32'd1);
        wr(A_N, 32'd100);
        wait_done("cnt100");
        rd_exp(A_W,    "cnt100_w",    32'd25);
        rd_exp(A_CNT,  "cnt100_cnt",  32'd25);
        rd_exp(A_CTRL, "cnt100_ctrl", 32'd1);

        // Rejected operands keep state, N and done
        wr(A_CTRL, 32'd0);
        wr(A_N, 32'd0);
        rd_exp(A_S, "n0_s", 32'd12);
        wr(A_N, 32'd1001);
        rd_exp(A_S, "n1001_s", 32'd12);
        rd_exp(A_N, "n1001_n_kept", 32'd100);
        wr(A_N, 32'd1);
        wait_done("m0n1");
        rd_exp(A_S, "m0n1_s", 32'd4);
        rd_exp(A_W, "m0n1_w", 32'd2);
        wr(A_CTRL, 32'd1);
        wr(A_N, 32'd1);
        wait_done("m1n1");
        rd_exp(A_W,   "m1n1_w",   32'd0);
        rd_exp(A_CNT, "m1n1_cnt", 32'd0);

        // Abort after 200 steps of N=500: primes up to 47 are counted by then
        wr(A_CTRL, 32'd0);
        wr(A_N, 32'd500);
        repeat (200) @(posedge clk);
        wr(A_CTRL, 32'd2);
        rd_exp(A_S,   "abort_s",   32'd0);
        rd_exp(A_W,   "abort_w",   32'd0);
        rd_exp(A_CNT, "abort_cnt", 32'd15);
        repeat (50) @(posedge clk);
        rd_exp(A_CNT, "abort_cnt_frozen", 32'd15);
        check("abort_gpio_out", gpio_out, 32'd15);
        wr(A_N, 32'd200);
        wait_done("n200");
        rd_exp(A_W,   "n200_w",   32'd1223);
        rd_exp(A_CNT, "n200_cnt", 32'd200);

        // Restart mid-run with a new N
        wr(A_N, 32'd900);
        repeat (100) @(posedge clk);
        wr(A_N, 32'd5);
        wait_done("restart5");
        rd_exp(A_W,   "restart5_w",   32'd11);
        rd_exp(A_CNT, "restart5_cnt", 32'd5);
        rd_exp(A_N,   "restart5_n",   32'd5);

        // Reset in the middle of a count-mode run
        wr(A_CTRL, 32'd1);
        wr(A_N, 32'd900);
        repeat (100) @(posedge clk);
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        rd_exp(A_N,    "mrst_n",    32'd0);
        rd_exp(A_CTRL, "mrst_ctrl", 32'd0);
        rd_exp(A_W,    "mrst_w",    32'd0);
        rd_exp(A_CNT,  "mrst_cnt",  32'd0);
        rd_exp(A_S,    "mrst_s",    32'd0);
        check("mrst_gpio_out", gpio_out, 32'd0);
        repeat (20) @(posedge clk);
        rd_exp(A_S, "mrst_s_later", 32'd0);

        // Level read strobe: one load only, even if the address moves
        wr(A_N, 32'd7);
        wait_done("n7");
        sb_q.push_back('{"hold_rd", 32'd7, 1'b0});
        @(negedge clk);
        bus.saddress = A_N;
        bus.srd      = 1'b1;
        prev_out     = bus.sdata_out;
        changes      = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.sdata_out !== prev_out)
                changes++;
            prev_out = bus.sdata_out;
            if (k == 1)
                bus.saddress = A_W;
        end
        bus.srd = 1'b0;
        check("hold_updates", 32'(changes), 32'd1);
        check("hold_value", bus.sdata_out, 32'd7);
        rd_exp(A_W, "n7_w", 32'd17);

        // gpio_in capture on the latch edge only
        @(negedge clk);
        gpio_in    = 32'hDEADBEEF;
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in    = 32'h12345678;
        repeat (3) @(negedge clk);
        check("insp_held", gpio_in_s_insp, 32'hDEADBEEF);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
